// File: rtl/cpu_types_pkg.sv
// Shared CPU types: request-unit state encoding and small decode helpers.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } reqstate_t;

  localparam int PERF_W_DEFAULT = 32;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit decode bundle; the ru modport is the request unit's view of it.
interface control_unit_if;
  logic memRead;
  logic memWrite;
  logic halt;

  modport cu (output memRead, output memWrite, output halt);
  modport ru (input memRead, input memWrite, input halt);
endinterface

// File: rtl/ru_sat_counter.sv
// Saturating up-counter for the request-unit performance counters.
module ru_sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [PERF_W-1:0] count_o
);

  logic [PERF_W-1:0] count_q, count_d;

  // Holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/request_unit.sv
// Request unit: sequences instruction fetch, data access and halt for the core.
// Optional perf counters are built when REQUEST_UNIT_PERF_EN is defined.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int PERF_W = PERF_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              halt,
  input  logic              ihit,
  input  logic              dhit,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              pcEn,
  output logic              halted,
  output logic [PERF_W-1:0] instr_cnt,
  output logic [PERF_W-1:0] stall_cnt,
  output reqstate_t         state_o
);

  control_unit_if cu_if ();

  assign cu_if.memRead  = memRead;
  assign cu_if.memWrite = memWrite;
  assign cu_if.halt     = halt;

  reqstate_t state_q, state_d;
  logic      dren_q, dren_d;
  logic      dwen_q, dwen_d;
  logic      halted_q, halted_d;
  logic      mem_op;

  always_comb begin
    state_d  = state_q;
    dren_d   = dren_q;
    dwen_d   = dwen_q;
    halted_d = halted_q;
    pcEn     = 1'b0;
    mem_op   = is_mem_op(cu_if.memRead, cu_if.memWrite);
    unique case (state_q)
      FETCH: begin
        if (ihit) begin
          if (cu_if.halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else if (mem_op) begin
            // A store takes priority when both load and store are decoded.
            state_d = DATA;
            dwen_d  = cu_if.memWrite;
            dren_d  = cu_if.memRead & ~cu_if.memWrite;
          end else begin
            pcEn = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pcEn    = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= FETCH;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dren_q   <= dren_d;
      dwen_q   <= dwen_d;
      halted_q <= halted_d;
    end
  end

  assign iREN    = (state_q == FETCH);
  assign dREN    = dren_q;
  assign dWEN    = dwen_q;
  assign halted  = halted_q;
  assign state_o = state_q;

`ifdef REQUEST_UNIT_PERF_EN
  logic stall_en;

  // A stall is any fetch or data cycle still waiting on its memory hit.
  assign stall_en = ((state_q == FETCH) && !ihit) || ((state_q == DATA) && !dhit);

  ru_sat_counter #(.PERF_W(PERF_W)) u_instr_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (pcEn),
    .count_o (instr_cnt)
  );

  ru_sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (stall_en),
    .count_o (stall_cnt)
  );
`else
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
